// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: req/ack data-bus handshake with pipeline stall, load-data
// lane extraction and extension, and misaligned / bus-timeout exception reporting.
module mem_lsu #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MAX_WAIT   = 15,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                req_valid_i,
    input  logic                req_we_i,
    input  logic [1:0]          req_size_i,
    input  logic                req_uns_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    output logic                stall_o,
    output logic                resp_valid_o,
    output logic [DATA_W-1:0]   resp_rdata_o,
    output logic                exc_valid_o,
    output logic [4:0]          exc_code_o,
    output logic [ADDR_W-1:0]   exc_badaddr_o,
    output logic                mem_ce_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W/8-1:0] mem_sel_o,
    output logic [DATA_W-1:0]   mem_data_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_data_i
);
    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned LB = $clog2(NB);
    localparam logic [4:0] ExcAdEL = 5'd4;
    localparam logic [4:0] ExcAdES = 5'd5;
    localparam logic [4:0] ExcDbe  = 5'd7;
    localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              mem_ce_q, mem_ce_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [NB-1:0]     mem_sel_q, mem_sel_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              exc_valid_q, exc_valid_d;
    logic [4:0]        exc_code_q, exc_code_d;
    logic [ADDR_W-1:0] exc_badaddr_q, exc_badaddr_d;

    logic              misaligned;
    logic [2:0]        align_mask;
    logic [NB-1:0]     le_mask, sel_req;
    logic [DATA_W-1:0] wdata_rep, shifted, load_data;
    int unsigned       nbytes, off, shamt;

    // Request decode: alignment, lane enables and write-data replication.
    always_comb begin
        align_mask = 3'((4'd1 << req_size_i) - 4'd1);
        misaligned = ((req_size_i == 2'd3) && (DATA_W == 32)) ||
                     ((req_addr_i[2:0] & align_mask) != 3'd0);
        le_mask = NB'((32'd1 << (32'd1 << req_size_i)) - 32'd1) << req_addr_i[LB-1:0];
        for (int i = 0; i < NB; i++) begin
            sel_req[i] = BIG_ENDIAN ? le_mask[NB-1-i] : le_mask[i];
        end
        case (req_size_i)
            2'd0:    wdata_rep = {NB{req_wdata_i[7:0]}};
            2'd1:    wdata_rep = {(NB/2){req_wdata_i[15:0]}};
            2'd2:    wdata_rep = {(NB/4){req_wdata_i[31:0]}};
            default: wdata_rep = req_wdata_i;
        endcase
    end

    // Right-justify the addressed element, then extend it to the full width.
    always_comb begin
        nbytes  = 32'd1 << size_q;
        off     = 32'(addr_q[LB-1:0]);
        shamt   = BIG_ENDIAN ? 8 * (NB - off - nbytes) : 8 * off;
        shifted = mem_data_i >> shamt;
        load_data = shifted;
        case (size_q)
            2'd0: begin
                if (uns_q) load_data = DATA_W'(shifted[7:0]);
                else       load_data = DATA_W'($signed(shifted[7:0]));
            end
            2'd1: begin
                if (uns_q) load_data = DATA_W'(shifted[15:0]);
                else       load_data = DATA_W'($signed(shifted[15:0]));
            end
            2'd2: begin
                if (uns_q) load_data = DATA_W'(shifted[31:0]);
                else       load_data = DATA_W'($signed(shifted[31:0]));
            end
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        size_d        = size_q;
        uns_d         = uns_q;
        mem_ce_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = '0;
        mem_sel_d     = '0;
        mem_data_d    = '0;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = '0;
        exc_valid_d   = 1'b0;
        exc_code_d    = '0;
        exc_badaddr_d = '0;
        if (flush_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i && misaligned) begin
                        state_d       = StDone;
                        exc_valid_d   = 1'b1;
                        exc_code_d    = req_we_i ? ExcAdES : ExcAdEL;
                        exc_badaddr_d = req_addr_i;
                    end else if (req_valid_i) begin
                        state_d    = StBusy;
                        cnt_d      = '0;
                        addr_d     = req_addr_i;
                        size_d     = req_size_i;
                        uns_d      = req_uns_i;
                        mem_ce_d   = 1'b1;
                        mem_we_d   = req_we_i;
                        mem_addr_d = {req_addr_i[ADDR_W-1:LB], {LB{1'b0}}};
                        mem_sel_d  = sel_req;
                        mem_data_d = wdata_rep;
                    end
                end
                StBusy: begin
                    if (mem_ack_i) begin
                        state_d      = StDone;
                        cnt_d        = '0;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = mem_we_q ? '0 : load_data;
                    end else if (cnt_q == WaitLast) begin
                        state_d       = StDone;
                        cnt_d         = '0;
                        exc_valid_d   = 1'b1;
                        exc_code_d    = ExcDbe;
                        exc_badaddr_d = addr_q;
                    end else begin
                        cnt_d      = cnt_q + 8'd1;
                        mem_ce_d   = 1'b1;
                        mem_we_d   = mem_we_q;
                        mem_addr_d = mem_addr_q;
                        mem_sel_d  = mem_sel_q;
                        mem_data_d = mem_data_q;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            addr_q        <= '0;
            size_q        <= '0;
            uns_q         <= 1'b0;
            mem_ce_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_sel_q     <= '0;
            mem_data_q    <= '0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
            exc_valid_q   <= 1'b0;
            exc_code_q    <= '0;
            exc_badaddr_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            size_q        <= size_d;
            uns_q         <= uns_d;
            mem_ce_q      <= mem_ce_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_sel_q     <= mem_sel_d;
            mem_data_q    <= mem_data_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            exc_valid_q   <= exc_valid_d;
            exc_code_q    <= exc_code_d;
            exc_badaddr_q <= exc_badaddr_d;
        end
    end

    assign stall_o       = req_valid_i & ~(resp_valid_q | exc_valid_q);
    assign resp_valid_o  = resp_valid_q;
    assign resp_rdata_o  = resp_rdata_q;
    assign exc_valid_o   = exc_valid_q;
    assign exc_code_o    = exc_code_q;
    assign exc_badaddr_o = exc_badaddr_q;
    assign mem_ce_o      = mem_ce_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_sel_o     = mem_sel_q;
    assign mem_data_o    = mem_data_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a 32-bit big-endian and a 64-bit little-endian instance.
module tb_mem_lsu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        flush, req_valid, req_we, req_uns, mem_ack, use64;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, mem_rdata;

    logic        stall32, resp_v32, exc_v32, ce32, we32;
    logic [31:0] rdata32, bad32, maddr32, mdata32;
    logic [4:0]  code32;
    logic [3:0]  sel32;
    logic        stall64, resp_v64, exc_v64, ce64, we64;
    logic [63:0] rdata64, mdata64;
    logic [31:0] bad64, maddr64;
    logic [4:0]  code64;
    logic [7:0]  sel64;

    mem_lsu u_dut32 (
        .clk(clk), .rst(rst), .flush_i(flush), .req_valid_i(req_valid & ~use64),
        .req_we_i(req_we), .req_size_i(req_size), .req_uns_i(req_uns), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata[31:0]), .stall_o(stall32), .resp_valid_o(resp_v32),
        .resp_rdata_o(rdata32), .exc_valid_o(exc_v32), .exc_code_o(code32),
        .exc_badaddr_o(bad32), .mem_ce_o(ce32), .mem_we_o(we32), .mem_addr_o(maddr32),
        .mem_sel_o(sel32), .mem_data_o(mdata32), .mem_ack_i(mem_ack),
        .mem_data_i(mem_rdata[31:0])
    );

    mem_lsu #(.DATA_W(64), .BIG_ENDIAN(1'b0)) u_dut64 (
        .clk(clk), .rst(rst), .flush_i(flush), .req_valid_i(req_valid & use64),
        .req_we_i(req_we), .req_size_i(req_size), .req_uns_i(req_uns), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .stall_o(stall64), .resp_valid_o(resp_v64),
        .resp_rdata_o(rdata64), .exc_valid_o(exc_v64), .exc_code_o(code64),
        .exc_badaddr_o(bad64), .mem_ce_o(ce64), .mem_we_o(we64), .mem_addr_o(maddr64),
        .mem_sel_o(sel64), .mem_data_o(mdata64), .mem_ack_i(mem_ack), .mem_data_i(mem_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Results of the last access: bus view on its first bus cycle, response on completion.
    logic [7:0]  r_sel;
    logic [63:0] r_mdata, r_rdata;
    logic [31:0] r_maddr, r_bad;
    logic        r_mwe, r_resp, r_exc;
    logic [4:0]  r_code;
    int          r_lat, r_ce, r_stall_bad;

    task automatic access(input logic is64, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [63:0] wdata,
                          input int ack_at, input logic [63:0] rd);
        logic ce, st, rv, ev;
        r_sel = '0; r_mdata = '0; r_rdata = '0; r_maddr = '0; r_bad = '0;
        r_mwe = 1'b0; r_resp = 1'b0; r_exc = 1'b0; r_code = '0;
        r_lat = -1; r_ce = 0; r_stall_bad = 0;
        @(posedge clk); #1;
        use64 = is64; req_valid = 1'b1; req_we = we; req_size = size; req_uns = uns;
        req_addr = addr; req_wdata = wdata;
        for (int c = 0; c < 40; c++) begin
            mem_ack = (c == ack_at);
            mem_rdata = rd;
            @(negedge clk);
            ce = is64 ? ce64 : ce32;
            st = is64 ? stall64 : stall32;
            rv = is64 ? resp_v64 : resp_v32;
            ev = is64 ? exc_v64 : exc_v32;
            if (ce) begin
                r_ce++;
                if (r_ce == 1) begin
                    r_sel   = is64 ? sel64 : {4'b0, sel32};
                    r_mdata = is64 ? mdata64 : {32'b0, mdata32};
                    r_maddr = is64 ? maddr64 : maddr32;
                    r_mwe   = is64 ? we64 : we32;
                end
            end
            if (rv || ev) begin
                r_lat = c; r_resp = rv; r_exc = ev;
                r_rdata = is64 ? rdata64 : {32'b0, rdata32};
                r_code  = is64 ? code64 : code32;
                r_bad   = is64 ? bad64 : bad32;
                if (st) r_stall_bad++;
                break;
            end
            if (!st) r_stall_bad++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_uns = 1'b0;
        mem_ack = 1'b0; use64 = 1'b0; req_size = '0; req_addr = '0; req_wdata = '0;
        mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst outs32", {ce32, we32, resp_v32, exc_v32, stall32, sel32, code32}, '0);
        check("rst data32", {rdata32, mdata32}, '0);
        check("rst outs64", {ce64, we64, resp_v64, exc_v64, stall64, sel64, code64}, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // LW 0x100, ack in cycle 1
        access(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 64'h0, 1, 64'h8899AABB);
        check("lw sel", r_sel, 8'hF);
        check("lw addr", r_maddr, 32'h100);
        check("lw we", r_mwe, 1'b0);
        check("lw lat", r_lat, 2);
        check("lw resp", {r_resp, r_exc}, 2'b10);
        check("lw rdata", r_rdata, 64'h8899AABB);
        check("lw stall", r_stall_bad, 0);
        check("lw ce", r_ce, 1);

        access(1'b0, 1'b0, 2'd0, 1'b0, 32'h103, 64'h0, 1, 64'h000000F0);
        check("lb sel", r_sel, 8'h1);
        check("lb rdata", r_rdata, 64'hFFFFFFF0);
        access(1'b0, 1'b0, 2'd0, 1'b1, 32'h103, 64'h0, 1, 64'h000000F0);
        check("lbu rdata", r_rdata, 64'h000000F0);
        access(1'b0, 1'b0, 2'd1, 1'b0, 32'h102, 64'h0, 3, 64'h00008001);
        check("lh sel", r_sel, 8'h3);
        check("lh rdata", r_rdata, 64'hFFFF8001);
        check("lh lat", r_lat, 4);
        access(1'b0, 1'b0, 2'd1, 1'b1, 32'h100, 64'h0, 1, 64'hBEEF0000);
        check("lhu sel", r_sel, 8'hC);
        check("lhu rdata", r_rdata, 64'h0000BEEF);

        // SH with no ack: bus-error timeout
        access(1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 64'h1234, -1, 64'h0);
        check("sh sel", r_sel, 8'h3);
        check("sh mdata", r_mdata, 64'h12341234);
        check("sh we", r_mwe, 1'b1);
        check("sh addr", r_maddr, 32'h100);
        check("sh exc", {r_resp, r_exc}, 2'b01);
        check("sh code", r_code, 5'd7);
        check("sh bad", r_bad, 32'h102);
        check("sh ce cycles", r_ce, 15);
        check("sh lat", r_lat, 16);
        check("sh stall", r_stall_bad, 0);

        // Ack on the last cycle before timeout wins
        access(1'b0, 1'b1, 2'd0, 1'b0, 32'h101, 64'hAB, 15, 64'h0);
        check("sb sel", r_sel, 8'h4);
        check("sb mdata", r_mdata, 64'hABABABAB);
        check("sb late ack", {r_resp, r_exc}, 2'b10);
        check("sb lat", r_lat, 16);

        // Misaligned accesses; the stray ack lands in DONE and must be ignored
        access(1'b0, 1'b0, 2'd1, 1'b0, 32'h101, 64'h0, 1, 64'h0);
        check("adel exc", {r_resp, r_exc}, 2'b01);
        check("adel code", r_code, 5'd4);
        check("adel bad", r_bad, 32'h101);
        check("adel lat", r_lat, 1);
        check("adel ce", r_ce, 0);
        access(1'b0, 1'b1, 2'd2, 1'b0, 32'h2, 64'h0, -1, 64'h0);
        check("ades code", {r_exc, r_code}, {1'b1, 5'd5});
        check("ades ce", r_ce, 0);
        access(1'b0, 1'b0, 2'd3, 1'b0, 32'h8, 64'h0, -1, 64'h0);
        check("ld32 code", {r_exc, r_code}, {1'b1, 5'd4});

        // Flush in BUSY together with ack
        @(posedge clk); #1;
        use64 = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h100;
        @(posedge clk); #1;
        flush = 1'b1; mem_ack = 1'b1; mem_rdata = 64'h11223344;
        @(negedge clk);
        check("flush busy", {ce32, stall32}, 2'b11);
        @(posedge clk); #1;
        flush = 1'b0; mem_ack = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("flush quiet", {resp_v32, exc_v32, ce32, stall32}, 4'b0000);
        @(posedge clk); #1;
        mem_ack = 1'b1;
        @(negedge clk);
        check("idle ack", {resp_v32, exc_v32, ce32}, 3'b000);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("idle ack after", {resp_v32, exc_v32, ce32}, 3'b000);

        // Reset mid-access
        @(posedge clk); #1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0; mem_ack = 1'b1;
        @(negedge clk);
        check("rst mid", {resp_v32, exc_v32, ce32, sel32}, '0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("rst mid after", {resp_v32, exc_v32, ce32}, 3'b000);

        // 64-bit little-endian instance
        access(1'b1, 1'b0, 2'd3, 1'b0, 32'h8, 64'h0, 1, 64'h0123456789ABCDEF);
        check("ld sel", r_sel, 8'hFF);
        check("ld addr", r_maddr, 32'h8);
        check("ld rdata", r_rdata, 64'h0123456789ABCDEF);
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'hC, 64'h0, 1, 64'h80000000_00000000);
        check("lw64 sel", r_sel, 8'hF0);
        check("lw64 addr", r_maddr, 32'h8);
        check("lw64 rdata", r_rdata, 64'hFFFFFFFF_80000000);
        access(1'b1, 1'b0, 2'd2, 1'b1, 32'hC, 64'h0, 1, 64'h80000000_00000000);
        check("lwu64 rdata", r_rdata, 64'h00000000_80000000);
        access(1'b1, 1'b0, 2'd0, 1'b0, 32'h9, 64'h0, 2, 64'h00000000_00007F00);
        check("lb64 sel", r_sel, 8'h02);
        check("lb64 rdata", r_rdata, 64'h7F);
        access(1'b1, 1'b1, 2'd1, 1'b0, 32'hE, 64'hBEEF, 1, 64'h0);
        check("sh64 sel", r_sel, 8'hC0);
        check("sh64 mdata", r_mdata, 64'hBEEFBEEF_BEEFBEEF);
        check("sh64 resp", {r_resp, r_exc, r_mwe}, 3'b101);
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h6, 64'h0, -1, 64'h0);
        check("lw64 mis", {r_exc, r_code, r_bad}, {1'b1, 5'd4, 32'h6});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
